csoc_exec_ctrl: RTL and testbench

Sequencer that drives the CSoC DUT test pins on behalf of the csoc_test command processor. It generates a gated, divided `csoc_clk`, scan-enable/test-mode and DUT reset for four operations: execute N cycles, free-run until stopped, scan-shift N bits, and reset the DUT for N cycles. The command processor issues one operation at a time over a valid/ready handshake and receives a one-cycle `done` pulse when it completes.

---
 rtl/csoc_exec_ctrl.sv | 174 +++++++++++++++++
 tb/tb_csoc_exec_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csoc_exec_ctrl.sv
// Test-pin sequencer for the CSoC DUT: generates a gated, divided csoc_clk plus
// scan/test-mode/reset pins for EXEC, FREE_RUN, SCAN and DUT_RESET operations.
module csoc_exec_ctrl #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_count,
  input  logic        stop,
  output logic        done,
  output logic [15:0] cycle_cnt,
  output logic        scan_req,
  input  logic        scan_sdi,
  output logic        scan_sdo,
  output logic        scan_sdo_valid,
  output logic        csoc_clk,
  output logic        csoc_rstn,
  output logic        csoc_test_se,
  output logic        csoc_test_tm,
  output logic        csoc_sdi,
  input  logic        csoc_sdo
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_DONE} state_e;
  typedef enum logic [1:0] {OP_EXEC, OP_FREE_RUN, OP_SCAN, OP_DUT_RESET} op_e;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [7:0]  phase_q, phase_d;
  logic        stop_q, stop_d;
  logic        done_q, done_d;
  logic        scan_req_q, scan_req_d;
  logic        scan_sdo_q, scan_sdo_d;
  logic        sdo_valid_q, sdo_valid_d;
  logic        clk_q, clk_d;
  logic        rstn_q, rstn_d;
  logic        se_q, se_d;
  logic        tm_q, tm_d;
  logic        sdi_q, sdi_d;
  logic        phase_end;
  logic        busy_next;

  assign phase_end = (phase_q == PHASE_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    cycle_cnt_d = cycle_cnt_q;
    stop_d      = stop_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d        = op_e'(cmd_op);
          remaining_d = (op_e'(cmd_op) == OP_DUT_RESET && cmd_count == 16'd0) ? 16'd1 : cmd_count;
          cycle_cnt_d = 16'd0;
          stop_d      = 1'b0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end)
          state_d = (remaining_q == 16'd0 && op_q != OP_FREE_RUN) ? S_HOLD : S_LOW;
      end
      S_LOW: begin
        if (phase_end) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (phase_end) begin
          if (op_q == OP_FREE_RUN) begin
            state_d = (stop_q || stop) ? S_HOLD : S_LOW;
          end else begin
            remaining_d = remaining_q - 16'd1;
            state_d     = (remaining_q == 16'd1) ? S_HOLD : S_LOW;
          end
        end
      end
      S_HOLD: begin
        if (phase_end) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (op_q == OP_FREE_RUN && stop &&
        (state_q == S_SETUP || state_q == S_LOW || state_q == S_HIGH))
      stop_d = 1'b1;

    if (state_d == S_HIGH && state_q != S_HIGH && cycle_cnt_q != 16'hFFFF)
      cycle_cnt_d = cycle_cnt_q + 16'd1;
  end

  // Outputs are registered from the next state so pins change on state-entry edges.
  always_comb begin
    busy_next = (state_d == S_SETUP) || (state_d == S_LOW) ||
                (state_d == S_HIGH)  || (state_d == S_HOLD);
    phase_d   = (busy_next && state_d == state_q) ? phase_q + 8'd1 : 8'd0;
    clk_d     = (state_d == S_HIGH);
    done_d    = (state_d == S_DONE);
    se_d      = 1'b0;
    tm_d      = 1'b0;
    rstn_d    = 1'b1;
    if (busy_next) begin
      if (op_d == OP_SCAN) begin
        se_d = 1'b1;
        tm_d = 1'b1;
      end
      if (op_d == OP_DUT_RESET) rstn_d = 1'b0;
    end
    scan_req_d  = (op_q == OP_SCAN) && (state_d == S_LOW) && (state_q != S_LOW);
    sdi_d       = scan_req_q ? scan_sdi : sdi_q;
    sdo_valid_d = (op_q == OP_SCAN) && (state_q == S_LOW) && (state_d == S_HIGH);
    scan_sdo_d  = sdo_valid_d ? csoc_sdo : scan_sdo_q;
  end

  // NOTE: synchronous reset clears every state bit; sequential state uses non-blocking only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_EXEC;
      remaining_q <= 16'd0;
      cycle_cnt_q <= 16'd0;
      phase_q     <= 8'd0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      scan_req_q  <= 1'b0;
      scan_sdo_q  <= 1'b0;
      sdo_valid_q <= 1'b0;
      clk_q       <= 1'b0;
      rstn_q      <= 1'b0;
      se_q        <= 1'b0;
      tm_q        <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      cycle_cnt_q <= cycle_cnt_d;
      phase_q     <= phase_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      scan_req_q  <= scan_req_d;
      scan_sdo_q  <= scan_sdo_d;
      sdo_valid_q <= sdo_valid_d;
      clk_q       <= clk_d;
      rstn_q      <= rstn_d;
      se_q        <= se_d;
      tm_q        <= tm_d;
      sdi_q       <= sdi_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign done           = done_q;
  assign cycle_cnt      = cycle_cnt_q;
  assign scan_req       = scan_req_q;
  assign scan_sdo       = scan_sdo_q;
  assign scan_sdo_valid = sdo_valid_q;
  assign csoc_clk       = clk_q;
  assign csoc_rstn      = rstn_q;
  assign csoc_test_se   = se_q;
  assign csoc_test_tm   = tm_q;
  assign csoc_sdi       = sdi_q;

endmodule

// File: tb/tb_csoc_exec_ctrl.sv
// Directed bench for csoc_exec_ctrl with CLK_DIV=2 and an 8-bit scan-chain model
// of the DUT; offsets below are clk cycles after the command-accept edge.
module tb_csoc_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic        stop;
  logic        done;
  logic [15:0] cycle_cnt;
  logic        scan_req;
  logic        scan_sdi;
  logic        scan_sdo;
  logic        scan_sdo_valid;
  logic        csoc_clk;
  logic        csoc_rstn;
  logic        csoc_test_se;
  logic        csoc_test_tm;
  logic        csoc_sdi;
  logic        csoc_sdo;

  int pass_cnt = 0;
  int total_cnt = 0;

  csoc_exec_ctrl #(.CLK_DIV(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_count      (cmd_count),
    .stop           (stop),
    .done           (done),
    .cycle_cnt      (cycle_cnt),
    .scan_req       (scan_req),
    .scan_sdi       (scan_sdi),
    .scan_sdo       (scan_sdo),
    .scan_sdo_valid (scan_sdo_valid),
    .csoc_clk       (csoc_clk),
    .csoc_rstn      (csoc_rstn),
    .csoc_test_se   (csoc_test_se),
    .csoc_test_tm   (csoc_test_tm),
    .csoc_sdi       (csoc_sdi),
    .csoc_sdo       (csoc_sdo)
  );

  always #5 clk = ~clk;

  // DUT scan chain: preloaded 0x3C, shifts toward bit 0 on csoc_clk rise when se=1.
  logic [7:0] chain;
  logic       chain_load;
  always @(posedge csoc_clk or posedge chain_load) begin
    if (chain_load)        chain <= 8'h3C;
    else if (csoc_test_se) chain <= {csoc_sdi, chain[7:1]};
  end
  assign csoc_sdo = chain[0];

  // Scan-in source: bits of scan_word LSB-first, advancing on each request.
  logic [7:0] scan_word;
  logic [3:0] scan_ptr;
  always @(posedge clk) begin
    if (rst)           scan_ptr <= 4'd0;
    else if (scan_req) scan_ptr <= scan_ptr + 4'd1;
  end
  assign scan_sdi = scan_word[scan_ptr[2:0]];

  // Observations from the last operation run through run_op.
  int          rises, first_rise, done_off, req_cnt, sdo_n;
  logic [7:0]  sdo_bits, chain_at_done;
  logic [15:0] cnt_at_done;
  logic        se_and, se_or, tm_and, tm_or, rstn_and, rstn_or;
  logic        se_at_done, tm_at_done, rstn_at_done, ready_at_done;
  logic        ready_at_accept, done_after, ready_after;

  // Issues one command from a negedge and observes it until done (200-cycle budget).
  task automatic run_op(input logic [1:0] op, input logic [15:0] cnt,
                        input bit poke, input int stop_after);
    logic prev_clk;
    int   stop_clr;
    rises = 0; first_rise = -1; done_off = -1; req_cnt = 0; sdo_n = 0;
    sdo_bits = 8'h00; chain_at_done = 8'h00; cnt_at_done = 16'hDEAD;
    se_and = 1'b1; se_or = 1'b0; tm_and = 1'b1; tm_or = 1'b0;
    rstn_and = 1'b1; rstn_or = 1'b0;
    se_at_done = 1'bx; tm_at_done = 1'bx; rstn_at_done = 1'bx; ready_at_done = 1'bx;
    ready_at_accept = cmd_ready;
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 16'd0;
    prev_clk = 1'b0;
    stop_clr = -1;
    for (int o = 0; o < 200; o++) begin
      if (o == stop_clr) stop = 1'b0;
      if (poke && o == 3) begin cmd_valid = 1'b1; cmd_op = 2'd0; cmd_count = 16'd7; end
      if (poke && o == 4) cmd_valid = 1'b0;
      if (csoc_clk && !prev_clk) begin
        rises++;
        if (first_rise < 0) first_rise = o;
        if (rises == stop_after) begin stop = 1'b1; stop_clr = o + 1; end
      end
      prev_clk = csoc_clk;
      if (scan_req) req_cnt++;
      if (scan_sdo_valid && sdo_n < 8) begin sdo_bits[sdo_n] = scan_sdo; sdo_n++; end
      if (done) begin
        done_off = o; cnt_at_done = cycle_cnt; chain_at_done = chain;
        se_at_done = csoc_test_se; tm_at_done = csoc_test_tm;
        rstn_at_done = csoc_rstn; ready_at_done = cmd_ready;
        break;
      end
      se_and &= csoc_test_se; se_or |= csoc_test_se;
      tm_and &= csoc_test_tm; tm_or |= csoc_test_tm;
      rstn_and &= csoc_rstn;  rstn_or |= csoc_rstn;
      @(negedge clk);
    end
    stop = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    done_after = done;
    ready_after = cmd_ready;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (csoc_rstn !== 1'b0) $display("FAIL reset_rstn: got %b expected 0", csoc_rstn); else pass_cnt++;
    total_cnt++; if (csoc_clk !== 1'b0) $display("FAIL reset_clk: got %b expected 0", csoc_clk); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 16'd0) $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); else pass_cnt++;
    total_cnt++; if ({csoc_test_se, csoc_test_tm, scan_req, scan_sdo_valid} !== 4'b0000)
      $display("FAIL reset_pins: got %b expected 0000", {csoc_test_se, csoc_test_tm, scan_req, scan_sdo_valid}); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (csoc_rstn !== 1'b1) $display("FAIL release_rstn: got %b expected 1", csoc_rstn); else pass_cnt++;
  endtask

  task automatic test_exec;
    run_op(2'd0, 16'd3, 1'b0, 1);  // stop pulse after the first rise must be ignored
    total_cnt++; if (ready_at_accept !== 1'b1) $display("FAIL exec_ready_accept: got %b expected 1", ready_at_accept); else pass_cnt++;
    total_cnt++; if (rises != 3) $display("FAIL exec_rises: got %0d expected 3", rises); else pass_cnt++;
    total_cnt++; if (first_rise != 4) $display("FAIL exec_first_rise: got %0d expected 4", first_rise); else pass_cnt++;
    total_cnt++; if (done_off != 16) $display("FAIL exec_done_time: got %0d expected 16", done_off); else pass_cnt++;
    total_cnt++; if (cnt_at_done !== 16'd3) $display("FAIL exec_cycle_cnt: got %0d expected 3", cnt_at_done); else pass_cnt++;
    total_cnt++; if ({se_or, tm_or} !== 2'b00) $display("FAIL exec_se_tm: got %b expected 00", {se_or, tm_or}); else pass_cnt++;
    total_cnt++; if (rstn_and !== 1'b1) $display("FAIL exec_rstn: got %b expected 1", rstn_and); else pass_cnt++;
    total_cnt++; if (ready_at_done !== 1'b0) $display("FAIL exec_ready_at_done: got %b expected 0", ready_at_done); else pass_cnt++;
    total_cnt++; if ({done_after, ready_after} !== 2'b01)
      $display("FAIL exec_after_done: got done=%b ready=%b expected 0 1", done_after, ready_after); else pass_cnt++;
  endtask

  task automatic test_exec_zero_back_to_back;
    run_op(2'd0, 16'd0, 1'b0, 0);
    total_cnt++; if (rises != 0) $display("FAIL zero_rises: got %0d expected 0", rises); else pass_cnt++;
    total_cnt++; if (done_off != 4) $display("FAIL zero_done_time: got %0d expected 4", done_off); else pass_cnt++;
    total_cnt++; if (cnt_at_done !== 16'd0) $display("FAIL zero_cycle_cnt: got %0d expected 0", cnt_at_done); else pass_cnt++;
    run_op(2'd0, 16'd5, 1'b1, 0);  // issued the cycle after done; busy-time cmd_valid poked
    total_cnt++; if (ready_at_accept !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", ready_at_accept); else pass_cnt++;
    total_cnt++; if (rises != 5) $display("FAIL busy_valid_rises: got %0d expected 5", rises); else pass_cnt++;
    total_cnt++; if (done_off != 24) $display("FAIL busy_valid_done_time: got %0d expected 24", done_off); else pass_cnt++;
    total_cnt++; if (cnt_at_done !== 16'd5) $display("FAIL busy_valid_cycle_cnt: got %0d expected 5", cnt_at_done); else pass_cnt++;
    total_cnt++; if (ready_after !== 1'b1) $display("FAIL busy_valid_not_queued: got ready=%b expected 1", ready_after); else pass_cnt++;
  endtask

  task automatic test_scan;
    scan_word = 8'hA5;
    run_op(2'd2, 16'd8, 1'b0, 0);
    total_cnt++; if (req_cnt != 8) $display("FAIL scan_req_count: got %0d expected 8", req_cnt); else pass_cnt++;
    total_cnt++; if (sdo_n != 8) $display("FAIL scan_sdo_count: got %0d expected 8", sdo_n); else pass_cnt++;
    total_cnt++; if (sdo_bits !== 8'h3C) $display("FAIL scan_sdo_bits: got %h expected 3c", sdo_bits); else pass_cnt++;
    total_cnt++; if (chain_at_done !== 8'hA5) $display("FAIL scan_chain: got %h expected a5", chain_at_done); else pass_cnt++;
    total_cnt++; if (rises != 8) $display("FAIL scan_rises: got %0d expected 8", rises); else pass_cnt++;
    total_cnt++; if (done_off != 36) $display("FAIL scan_done_time: got %0d expected 36", done_off); else pass_cnt++;
    total_cnt++; if ({se_and, tm_and} !== 2'b11) $display("FAIL scan_se_tm_busy: got %b expected 11", {se_and, tm_and}); else pass_cnt++;
    total_cnt++; if ({se_at_done, tm_at_done, rstn_at_done} !== 3'b001)
      $display("FAIL scan_pins_at_done: got %b expected 001", {se_at_done, tm_at_done, rstn_at_done}); else pass_cnt++;
  endtask

  task automatic test_free_run;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    total_cnt++; if ({cmd_ready, done, csoc_clk} !== 3'b100)
      $display("FAIL idle_stop: got ready/done/clk=%b expected 100", {cmd_ready, done, csoc_clk}); else pass_cnt++;
    run_op(2'd1, 16'd3, 1'b0, 10);  // count ignored; stop raised in first HIGH cycle of rise 10
    total_cnt++; if (rises != 10) $display("FAIL free_rises: got %0d expected 10", rises); else pass_cnt++;
    total_cnt++; if (done_off != 44) $display("FAIL free_done_time: got %0d expected 44", done_off); else pass_cnt++;
    total_cnt++; if (cnt_at_done !== 16'd10) $display("FAIL free_cycle_cnt: got %0d expected 10", cnt_at_done); else pass_cnt++;
  endtask

  task automatic test_dut_reset;
    run_op(2'd3, 16'd2, 1'b0, 0);
    total_cnt++; if (rises != 2) $display("FAIL dutrst_rises: got %0d expected 2", rises); else pass_cnt++;
    total_cnt++; if (rstn_or !== 1'b0) $display("FAIL dutrst_rstn_busy: got %b expected 0", rstn_or); else pass_cnt++;
    total_cnt++; if (rstn_at_done !== 1'b1) $display("FAIL dutrst_rstn_done: got %b expected 1", rstn_at_done); else pass_cnt++;
    total_cnt++; if (done_off != 12) $display("FAIL dutrst_done_time: got %0d expected 12", done_off); else pass_cnt++;
    run_op(2'd3, 16'd0, 1'b0, 0);
    total_cnt++; if (rises != 1) $display("FAIL dutrst0_rises: got %0d expected 1", rises); else pass_cnt++;
    total_cnt++; if (done_off != 8) $display("FAIL dutrst0_done_time: got %0d expected 8", done_off); else pass_cnt++;
  endtask

  task automatic test_mid_op_reset;
    int seen_done;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_count = 16'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_count = 16'd0;
    repeat (8) @(negedge clk);
    total_cnt++; if (csoc_clk !== 1'b1) $display("FAIL midrst_pre_clk: got %b expected 1", csoc_clk); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if ({csoc_clk, csoc_rstn, done, cmd_ready} !== 4'b0001)
      $display("FAIL midrst_outputs: got clk/rstn/done/ready=%b expected 0001", {csoc_clk, csoc_rstn, done, cmd_ready}); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 16'd0) $display("FAIL midrst_cycle_cnt: got %0d expected 0", cycle_cnt); else pass_cnt++;
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    total_cnt++; if (seen_done != 0) $display("FAIL midrst_no_done: got %0d pulses expected 0", seen_done); else pass_cnt++;
    total_cnt++; if ({csoc_rstn, cmd_ready} !== 2'b11) $display("FAIL midrst_after: got rstn/ready=%b expected 11", {csoc_rstn, cmd_ready}); else pass_cnt++;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 16'd0;
    stop = 1'b0; scan_word = 8'h00;
    chain_load = 1'b1;
    #1 chain_load = 1'b0;
    test_reset;
    test_exec;
    test_exec_zero_back_to_back;
    test_scan;
    test_free_run;
    test_dut_reset;
    test_mid_op_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
